// File: rtl/mem_access_sequencer_pkg.sv
// Shared definitions for the MEM-stage access sequencer and the memory controller:
// state encoding, serial port addresses, bus access codes and status bit positions.
package mem_access_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RAM_ACC = 3'd1,
    ST_POLL_TX = 3'd2,
    ST_TX_WR   = 3'd3,
    ST_POLL_RX = 3'd4,
    ST_RX_RD   = 3'd5,
    ST_DONE    = 3'd6
  } seq_state_e;

  localparam logic [15:0] UART_DATA_ADDR = 16'hBF00;
  localparam logic [15:0] UART_STAT_ADDR = 16'hBF01;

  localparam logic [1:0] ACC_ACTIVE = 2'b01;
  localparam logic [1:0] ACC_IDLE   = 2'b00;

  localparam int TX_READY_BIT = 0;
  localparam int RX_READY_BIT = 1;

  function automatic logic [1:0] acc_code(input logic active);
    return active ? ACC_ACTIVE : ACC_IDLE;
  endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Bundles the pipeline request/response handshake and the memory controller bus.
// The sequencer uses the slave view; the pipeline/memory environment uses the master view.
interface mem_access_sequencer_if;

  logic        reqValid;
  logic        reqRead;
  logic        reqWrite;
  logic [15:0] reqAddr;
  logic [15:0] reqData;

  logic        stall;
  logic        respValid;
  logic [15:0] respData;
  logic        respErr;

  logic [15:0] address;
  logic [15:0] dataIn;
  logic [1:0]  memRead;
  logic [1:0]  memWrite;
  logic [15:0] dataOut;

  modport slave (
    input  reqValid, reqRead, reqWrite, reqAddr, reqData, dataOut,
    output stall, respValid, respData, respErr, address, dataIn, memRead, memWrite
  );

  modport master (
    output reqValid, reqRead, reqWrite, reqAddr, reqData, dataOut,
    input  stall, respValid, respData, respErr, address, dataIn, memRead, memWrite
  );

endinterface

// File: rtl/mem_access_sequencer_poll_timer.sv
// Counts failed serial status polls and flags the poll that would reach the limit,
// so the sequencer can abort instead of issuing one more poll.
module poll_timer #(
  parameter logic [15:0] LIMIT = 16'd4095
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic last
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Widened compare keeps a limit of 0 or 16'hFFFF from wrapping.
  assign last = ({1'b0, count_q} + 17'd1) >= {1'b0, LIMIT};

endmodule

// File: rtl/mem_access_sequencer.sv
// MEM-stage access sequencer: turns one pipeline access into either a single RAM
// cycle or a polled serial-port transfer, stalling the pipeline until it completes.
module mem_access_sequencer
  import mem_access_sequencer_pkg::*;
#(
  parameter logic [15:0] POLL_LIMIT = 16'd4095,
  parameter logic [15:0] UART_DATA  = UART_DATA_ADDR,
  parameter logic [15:0] UART_STAT  = UART_STAT_ADDR
) (
  input  logic                   CLK,
  input  logic                   RST,
  mem_access_sequencer_if.slave  bus
);

  seq_state_e  state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        is_read_q, is_read_d;
  logic        err_q, err_d;
  logic [15:0] resp_data_q, resp_data_d;

  logic        poll_clear;
  logic        poll_inc;
  logic        poll_last;

  poll_timer #(
    .LIMIT (POLL_LIMIT)
  ) u_poll_timer (
    .clk   (CLK),
    .rst_n (RST),
    .clear (poll_clear),
    .inc   (poll_inc),
    .last  (poll_last)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    is_read_d   = is_read_q;
    err_d       = err_q;
    resp_data_d = resp_data_q;
    poll_clear  = 1'b0;
    poll_inc    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.reqValid) begin
          addr_d    = bus.reqAddr;
          data_d    = bus.reqData;
          is_read_d = bus.reqRead;
          err_d     = 1'b0;
          // Malformed requests win over address decode and never touch the bus.
          if (bus.reqRead == bus.reqWrite) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (bus.reqAddr == UART_DATA) begin
            poll_clear = 1'b1;
            state_d    = bus.reqWrite ? ST_POLL_TX : ST_POLL_RX;
          end else if (bus.reqWrite && (bus.reqAddr == UART_STAT)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RAM_ACC;
          end
        end
      end

      ST_RAM_ACC: begin
        if (is_read_q) begin
          resp_data_d = bus.dataOut;
        end
        state_d = ST_DONE;
      end

      ST_POLL_TX: begin
        if (bus.dataOut[TX_READY_BIT]) begin
          state_d = ST_TX_WR;
        end else if (poll_last) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          poll_inc = 1'b1;
        end
      end

      ST_TX_WR: begin
        state_d = ST_DONE;
      end

      ST_POLL_RX: begin
        if (bus.dataOut[RX_READY_BIT]) begin
          state_d = ST_RX_RD;
        end else if (poll_last) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          poll_inc = 1'b1;
        end
      end

      ST_RX_RD: begin
        resp_data_d = bus.dataOut;
        state_d     = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      is_read_q   <= 1'b0;
      err_q       <= 1'b0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      is_read_q   <= is_read_d;
      err_q       <= err_d;
      resp_data_q <= resp_data_d;
    end
  end

  always_comb begin
    bus.address  = '0;
    bus.dataIn   = '0;
    bus.memRead  = ACC_IDLE;
    bus.memWrite = ACC_IDLE;

    case (state_q)
      ST_RAM_ACC: begin
        bus.address  = addr_q;
        bus.memRead  = acc_code(is_read_q);
        bus.memWrite = acc_code(!is_read_q);
        if (!is_read_q) begin
          bus.dataIn = data_q;
        end
      end
      ST_POLL_TX, ST_POLL_RX: begin
        bus.address = UART_STAT;
        bus.memRead = ACC_ACTIVE;
      end
      ST_TX_WR: begin
        bus.address  = UART_DATA;
        bus.dataIn   = data_q;
        bus.memWrite = ACC_ACTIVE;
      end
      ST_RX_RD: begin
        bus.address = UART_DATA;
        bus.memRead = ACC_ACTIVE;
      end
      default: begin
        bus.address = '0;
      end
    endcase
  end

  // Reset must drop stall at once even if upstream keeps reqValid asserted.
  assign bus.stall = RST && (((state_q == ST_IDLE) && bus.reqValid) ||
                             ((state_q != ST_IDLE) && (state_q != ST_DONE)));

  assign bus.respValid = (state_q == ST_DONE);
  assign bus.respErr   = (state_q == ST_DONE) && err_q;
  assign bus.respData  = resp_data_q;

endmodule
